// File: rtl/add_sub_serial_pkg.sv
// add_sub_serial_pkg: state encodings and index-width helper for the digit-serial adder/subtractor
package add_sub_serial_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
   function automatic int idx_width(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction
endpackage

// File: rtl/add_sub_slice.sv
// add_sub_slice: DIGIT-bit ripple of full adders exposing carry into the MSB for overflow detection
module add_sub_slice #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb
);
   logic [DIGIT:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      full_adder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .s(sum[i]), .cout(c[i+1]));
   end
   assign cout  = c[DIGIT];
   assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/add_sub_serial.sv
// add_sub_serial: digit-serial two's-complement adder/subtractor with start/done handshake and flags
module add_sub_serial
   import add_sub_serial_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int IW   = idx_width(NDIG);
   state_t                 state, state_nx;
   logic [WIDTH-1:0]       opa, opb, acc, acc_nx;
   logic [WIDTH+DIGIT-1:0] cat;
   logic [IW-1:0]          idx;
   logic [DIGIT-1:0]       sum;
   logic                   cy, cout, c_msb, accept, last;
   add_sub_slice #(.DIGIT(DIGIT)) u_slice (
      .a(opa[DIGIT-1:0]), .b(opb[DIGIT-1:0]), .cin(cy),
      .sum(sum), .cout(cout), .c_msb(c_msb)
   );
   always_comb begin
      accept   = start && (state != ST_RUN);
      last     = idx == IW'(NDIG - 1);
      cat      = {sum, acc};
      acc_nx   = cat[WIDTH+DIGIT-1:DIGIT];
      state_nx = (state == ST_RUN) ? (last ? ST_DONE : ST_RUN) : (start ? ST_RUN : ST_IDLE);
      busy     = state == ST_RUN;
      done     = state == ST_DONE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         opa       <= '0;
         opb       <= '0;
         acc       <= '0;
         cy        <= 1'b0;
         idx       <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         negative  <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            opa <= a;
            opb <= b ^ {WIDTH{sub}};
            cy  <= sub;
            idx <= '0;
         end else if (state == ST_RUN) begin
            opa <= opa >> DIGIT;
            opb <= opb >> DIGIT;
            cy  <= cout;
            idx <= idx + 1'b1;
            acc <= acc_nx;
            if (last) begin
               result    <= acc_nx;
               carry_out <= cout;
               overflow  <= c_msb ^ cout;
               zero      <= acc_nx == '0;
               negative  <= acc_nx[WIDTH-1];
            end
         end
      end
   end
endmodule
